// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns a FIFO read port (rinc -> rvalid one cycle later) into a valid/ready stream
// through a small circular output buffer, with flush, transfer counting and a sticky protocol-error flag.
module fifo_rd_stream #(
  parameter int DW = 16,
  parameter int OBUF = 2
) (
  input  logic          rclk,
  input  logic          rrst_n,
  input  logic          rempty,
  input  logic [DW-1:0] rdata,
  input  logic          rvalid,
  output logic          rinc,
  input  logic          flush,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [31:0]   xfer_cnt,
  output logic          rd_err
);
  logic [DW-1:0] mem [4];
  logic [1:0] head, tail;
  logic [2:0] count, pend, disc, pend_n;
  logic [31:0] cnt;
  logic pop, push, arrive;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'(OBUF - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign m_valid = count != 3'd0;
  assign m_data = mem[head];
  assign xfer_cnt = cnt;
  assign pop = m_valid && m_ready && !flush;
  assign arrive = rvalid && pend != 3'd0;
  // oldest outstanding words are the discarded ones, so they are consumed first
  assign push = arrive && disc == 3'd0 && !flush && count != 3'(OBUF);
  // a pop this cycle frees a slot, which is what sustains one word per cycle
  assign rinc = rrst_n && !rempty && !flush &&
                ({1'b0, count} + {1'b0, pend}) < (4'(OBUF) + 4'(pop));
  assign pend_n = pend + 3'(rinc) - 3'(arrive);

  always_ff @(posedge rclk or negedge rrst_n)
    if (!rrst_n) begin
      count <= '0;
      pend <= '0;
      disc <= '0;
      head <= '0;
      tail <= '0;
      cnt <= '0;
      rd_err <= 1'b0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      pend <= pend_n;
      disc <= flush ? pend_n : disc - 3'(arrive && disc != 3'd0);
      count <= flush ? 3'd0 : count + 3'(push) - 3'(pop);
      head <= flush ? 2'd0 : pop ? nxt(head) : head;
      tail <= flush ? 2'd0 : push ? nxt(tail) : tail;
      if (push) mem[tail] <= rdata;
      if (pop) cnt <= cnt + 32'd1;
      if (rvalid && (pend == 3'd0 || count == 3'(OBUF))) rd_err <= 1'b1;
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: drives a modelled 1-cycle-latency FIFO and a random sink; a queue of expected
// buffered words is checked by an independent monitor.
module tb_fifo_rd_stream;
  localparam int OBUF = 2;
  logic rclk = 1'b0, rrst_n = 1'b1, rempty = 1'b1, rvalid = 1'b0, flush = 1'b0, m_ready = 1'b0;
  logic [15:0] rdata = '0;
  logic rinc, m_valid, rd_err;
  logic [15:0] m_data;
  logic [31:0] xfer_cnt;

  fifo_rd_stream #(.DW(16), .OBUF(OBUF)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rvalid(rvalid),
    .rinc(rinc), .flush(flush), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .xfer_cnt(xfer_cnt), .rd_err(rd_err)
  );

  always #5 rclk = ~rclk;

  int vectors = 0, miscompares = 0;
  logic [15:0] exp_q[$];
  int pend_m = 0, src_left = 0;
  bit err_m = 0, arr_v = 0, pop_m;
  logic [31:0] xfer_m = '0, x0;
  logic [15:0] arr_d = '0, next_word = 16'd1, got;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: samples 1ns after the falling edge, after the driver has set this cycle's inputs
  always @(negedge rclk) begin
    #1;
    pop_m = exp_q.size() != 0 && m_ready && !flush;
    chk("rinc", rinc, rrst_n && !rempty && !flush && (exp_q.size() + pend_m < OBUF + int'(pop_m)));
    chk("m_valid", m_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("m_data", m_data, exp_q[0]);
    chk("rd_err", rd_err, err_m);
    if (m_valid && m_ready && !flush) begin
      if (exp_q.size() == 0) chk("unexpected_word", 1'b1, 1'b0);
      else begin
        got = exp_q.pop_front();
        chk("word", m_data, got);
        chk("xfer_cnt", xfer_cnt, xfer_m);
        xfer_m++;
      end
    end
    if (flush) exp_q.delete();
  end

  task automatic step(input bit rdy, input bit fl, input bit inject);
    @(negedge rclk);
    rempty = src_left == 0;
    m_ready = rdy;
    flush = fl;
    rvalid = arr_v || inject;
    rdata = arr_v ? arr_d : 16'hDEAD;
    pend_m = int'(arr_v);
    #2;
    if (inject && !arr_v) err_m = 1;
    if (arr_v && !fl) exp_q.push_back(arr_d);
    arr_v = rinc;
    if (rinc) begin
      arr_d = next_word;
      next_word++;
      src_left--;
    end
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    exp_q.delete();
    arr_v = 0; pend_m = 0; err_m = 0; xfer_m = '0; src_left = 0;
    rvalid = 1'b0; flush = 1'b0; m_ready = 1'b0; rempty = 1'b1;
    repeat (2) @(negedge rclk);
    #3 rrst_n = 1'b1;
  endtask

  initial begin
    #1 rrst_n = 1'b0;
    @(negedge rclk);
    #3;
    chk("rst_rinc", rinc, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_xfer", xfer_cnt, 0);
    chk("rst_err", rd_err, 0);
    do_reset();
    // four words streamed with a ready sink
    src_left = 4;
    repeat (8) step(1, 0, 0);
    chk("xfer4", xfer_cnt, 4);
    // stalled sink: only OBUF requests go out, head word held
    src_left = 4;
    repeat (5) step(0, 0, 0);
    chk("hold_data", m_data, 16'd5);
    repeat (8) step(1, 0, 0);
    // flush with one buffered word and one arriving
    x0 = xfer_m;
    src_left = 2;
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    repeat (3) step(1, 0, 0);
    chk("flush_xfer", xfer_cnt, x0);
    // spurious rvalid sets a sticky error
    repeat (2) step(1, 0, 0);
    step(1, 0, 1);
    repeat (4) step(1, 0, 0);
    chk("err_sticky", rd_err, 1);
    do_reset();
    step(0, 0, 0);
    // counter wrap
    force dut.cnt = 32'hFFFF_FFFE;
    #1 release dut.cnt;
    xfer_m = 32'hFFFF_FFFE;
    src_left = 3;
    repeat (8) step(1, 0, 0);
    chk("wrap", xfer_cnt, 32'h1);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) src_left += int'($urandom_range(0, 5));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, 0);
    end
    src_left = 0;
    repeat (6) step(1, 0, 0);
    chk("final_xfer", xfer_cnt, xfer_m);
    chk("final_err", rd_err, 0);
    // asynchronous reset mid-burst, then a stray rvalid right after release
    src_left = 20;
    repeat (4) step(1, 0, 0);
    #1 rrst_n = 1'b0;
    #1;
    chk("async_rinc", rinc, 0);
    chk("async_m_valid", m_valid, 0);
    chk("async_m_data", m_data, 0);
    chk("async_xfer", xfer_cnt, 0);
    chk("async_err", rd_err, 0);
    do_reset();
    step(0, 0, 1);
    repeat (2) step(0, 0, 0);
    chk("post_rst_err", rd_err, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
